dp_sram_bank: RTL and testbench

Parametrised true-dual-port on-chip buffer for the CNN accelerator's input/output feature-map storage. It replaces the fixed 32768x16 dual-port macro model with configurable width and depth, per-byte write enables, an optional output pipeline register, deterministic same-address collision arbitration with a selectable read-during-write mode, and a post-reset memory clear engine. Both ports sit between the layer controller (port A) and the PE array/DMA (port B).

---
 rtl/dp_sram_bank.sv | 219 +++++++++++++++++++++
 tb/tb_dp_sram_bank.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_sram_bank.sv
// dp_sram_bank: parametrised true-dual-port feature-map buffer.
// Two independent request ports share one array. The bank supports per-byte
// write enables, deterministic lane-wise collision arbitration, selectable
// cross-port read-during-write behaviour, an optional extra output stage and
// a post-reset sweep that zeroes the whole array.
module dp_sram_bank #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 15,
  parameter int BYTE_W         = 8,
  parameter int OUT_REG        = 0,
  parameter int COLL_PRI       = 0,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       init_done,
  input  logic                       a_cs,
  input  logic                       a_we,
  input  logic [DATA_W/BYTE_W-1:0]   a_be,
  input  logic [ADDR_W-1:0]          a_addr,
  input  logic [DATA_W-1:0]          a_wdata,
  output logic [DATA_W-1:0]          a_rdata,
  output logic                       a_rvalid,
  input  logic                       b_cs,
  input  logic                       b_we,
  input  logic [DATA_W/BYTE_W-1:0]   b_be,
  input  logic [ADDR_W-1:0]          b_addr,
  input  logic [DATA_W-1:0]          b_wdata,
  output logic [DATA_W-1:0]          b_rdata,
  output logic                       b_rvalid,
  output logic                       coll_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BE_W  = DATA_W / BYTE_W;

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                clr_we;
  logic                init_done_q;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                wr_a, wr_b, rd_a, rd_b, same_addr;
  logic [DATA_W-1:0]   old_a, old_b, new_a, new_b;
  logic [DATA_W-1:0]   rd_word_a, rd_word_b;
  logic                coll_d;

  logic                a_v0_q, b_v0_q;
  logic [DATA_W-1:0]   a_d0_q, b_d0_q;
  logic                a_vs, b_vs;
  logic [DATA_W-1:0]   a_ds, b_ds;

  logic                a_rvalid_q, b_rvalid_q, coll_err_q;
  logic [DATA_W-1:0]   a_rdata_q, b_rdata_q;

  // Clear sweep / run sequencing: one zero write per cycle until the last address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // State register; init_done trails entry into RUN by one edge so that
  // requests are only honoured once the sweep has fully completed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= (state_q == S_RUN);
    end
  end

  // Request qualification and lane-wise merge of both ports' writes.
  // new_a/new_b are the words each port's address will hold after this edge,
  // so a same-address double write stores one identical word from both ports.
  always_comb begin
    wr_a      = init_done_q & a_cs & a_we;
    wr_b      = init_done_q & b_cs & b_we;
    rd_a      = init_done_q & a_cs & ~a_we;
    rd_b      = init_done_q & b_cs & ~b_we;
    same_addr = (a_addr == b_addr);
    old_a     = mem_q[a_addr];
    old_b     = mem_q[b_addr];
    new_a     = old_a;
    new_b     = old_b;
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (wr_a && a_be[i] && wr_b && b_be[i] && same_addr) begin
        new_a[i*BYTE_W +: BYTE_W] = (COLL_PRI != 0) ? b_wdata[i*BYTE_W +: BYTE_W]
                                                    : a_wdata[i*BYTE_W +: BYTE_W];
        new_b[i*BYTE_W +: BYTE_W] = new_a[i*BYTE_W +: BYTE_W];
      end else begin
        if (wr_a && a_be[i]) begin
          new_a[i*BYTE_W +: BYTE_W] = a_wdata[i*BYTE_W +: BYTE_W];
        end else if (wr_b && b_be[i] && same_addr) begin
          new_a[i*BYTE_W +: BYTE_W] = b_wdata[i*BYTE_W +: BYTE_W];
        end
        if (wr_b && b_be[i]) begin
          new_b[i*BYTE_W +: BYTE_W] = b_wdata[i*BYTE_W +: BYTE_W];
        end else if (wr_a && a_be[i] && same_addr) begin
          new_b[i*BYTE_W +: BYTE_W] = a_wdata[i*BYTE_W +: BYTE_W];
        end
      end
    end
    rd_word_a = (RDW_MODE != 0) ? old_a : new_a;
    rd_word_b = (RDW_MODE != 0) ? old_b : new_b;
    coll_d    = wr_a & wr_b & same_addr & (|(a_be & b_be));
  end

  // Array update: clear sweep or port writes; contents are never reset directly.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clr_we) begin
        mem_q[cnt_q] <= '0;
      end
      if (wr_a) begin
        mem_q[a_addr] <= new_a;
      end
      if (wr_b) begin
        mem_q[b_addr] <= new_b;
      end
    end
  end

  // First read stage: capture the selected word at the request edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_v0_q <= 1'b0;
      b_v0_q <= 1'b0;
      a_d0_q <= '0;
      b_d0_q <= '0;
    end else begin
      a_v0_q <= rd_a;
      b_v0_q <= rd_b;
      if (rd_a) a_d0_q <= rd_word_a;
      if (rd_b) b_d0_q <= rd_word_b;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic              a_v1_q, b_v1_q;
    logic [DATA_W-1:0] a_d1_q, b_d1_q;

    // Optional extra pipeline stage between capture and output.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        a_v1_q <= 1'b0;
        b_v1_q <= 1'b0;
        a_d1_q <= '0;
        b_d1_q <= '0;
      end else begin
        a_v1_q <= a_v0_q;
        b_v1_q <= b_v0_q;
        if (a_v0_q) a_d1_q <= a_d0_q;
        if (b_v0_q) b_d1_q <= b_d0_q;
      end
    end

    assign a_vs = a_v1_q;
    assign b_vs = b_v1_q;
    assign a_ds = a_d1_q;
    assign b_ds = b_d1_q;
  end else begin : g_noreg
    assign a_vs = a_v0_q;
    assign b_vs = b_v0_q;
    assign a_ds = a_d0_q;
    assign b_ds = b_d0_q;
  end

  // Output registers: rdata holds between reads, rvalid/coll_err are pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      coll_err_q <= 1'b0;
    end else begin
      a_rvalid_q <= a_vs;
      b_rvalid_q <= b_vs;
      if (a_vs) a_rdata_q <= a_ds;
      if (b_vs) b_rdata_q <= b_ds;
      coll_err_q <= coll_d;
    end
  end

  assign init_done = init_done_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign coll_err  = coll_err_q;

endmodule

// File: tb/tb_dp_sram_bank.sv
// Testbench for dp_sram_bank: two instances with different arbitration,
// read-during-write and latency settings share one stimulus stream and are
// checked every cycle against an array-based reference model.
module tb_dp_sram_bank;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int BW    = 2;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_cs, a_we, b_cs, b_we;
  logic [BW-1:0] a_be, b_be;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;

  logic          id [2];
  logic          av [2];
  logic          bv [2];
  logic          ce [2];
  logic [DW-1:0] ar [2];
  logic [DW-1:0] br [2];

  int n_cmp = 0;
  int n_err = 0;

  // Instance 0: port A wins collisions, write-first, latency 1.
  dp_sram_bank #(.DATA_W(DW), .ADDR_W(AW), .BYTE_W(8), .OUT_REG(0),
                 .COLL_PRI(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rst_n(rst_n), .init_done(id[0]),
    .a_cs(a_cs), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(ar[0]), .a_rvalid(av[0]),
    .b_cs(b_cs), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(br[0]), .b_rvalid(bv[0]), .coll_err(ce[0]));

  // Instance 1: port B wins collisions, read-first, latency 2.
  dp_sram_bank #(.DATA_W(DW), .ADDR_W(AW), .BYTE_W(8), .OUT_REG(1),
                 .COLL_PRI(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .rst_n(rst_n), .init_done(id[1]),
    .a_cs(a_cs), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(ar[1]), .a_rvalid(av[1]),
    .b_cs(b_cs), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(br[1]), .b_rvalid(bv[1]), .coll_err(ce[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Instance c uses: winner = (c==1 ? B : A), read-first when c==1, latency c+1.
  logic [DW-1:0] mm [2][DEPTH];
  logic          hv [2][2][4];
  logic [DW-1:0] hd [2][2][4];
  logic          ex_v  [2][2];
  logic [DW-1:0] ex_rd [2][2];
  logic          ex_ce [2];
  logic          ex_id;
  int unsigned   k;

  function automatic logic [DW-1:0] word_after(int c, logic [AW-1:0] addr);
    logic [DW-1:0] w;
    logic ha, hb;
    w = mm[c][addr];
    for (int i = 0; i < BW; i++) begin
      ha = a_cs && a_we && (a_addr == addr) && a_be[i];
      hb = b_cs && b_we && (b_addr == addr) && b_be[i];
      if (ha && (!hb || c == 0)) w[i*8 +: 8] = a_wdata[i*8 +: 8];
      else if (hb)               w[i*8 +: 8] = b_wdata[i*8 +: 8];
    end
    return w;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      k = 0;
      ex_id = 1'b0;
      for (int c = 0; c < 2; c++) begin
        ex_ce[c] = 1'b0;
        for (int p = 0; p < 2; p++) begin
          ex_v[c][p]  = 1'b0;
          ex_rd[c][p] = '0;
          for (int s = 0; s < 4; s++) begin
            hv[c][p][s] = 1'b0;
            hd[c][p][s] = '0;
          end
        end
      end
    end else begin
      logic acc;
      logic [DW-1:0] oa, ob, na, nb;
      int slot, ps;
      k++;
      if (k <= DEPTH) begin
        for (int c = 0; c < 2; c++) mm[c][k-1] = '0;
      end
      acc  = (k >= DEPTH + 2);
      slot = int'(k % 4);
      for (int c = 0; c < 2; c++) begin
        oa = mm[c][a_addr];
        ob = mm[c][b_addr];
        na = word_after(c, a_addr);
        nb = word_after(c, b_addr);
        hv[c][0][slot] = acc && a_cs && !a_we;
        hv[c][1][slot] = acc && b_cs && !b_we;
        hd[c][0][slot] = (c == 1) ? oa : na;
        hd[c][1][slot] = (c == 1) ? ob : nb;
        ex_ce[c] = acc && a_cs && a_we && b_cs && b_we && (a_addr == b_addr) && ((a_be & b_be) != 0);
        if (acc && a_cs && a_we) mm[c][a_addr] = na;
        if (acc && b_cs && b_we) mm[c][b_addr] = nb;
        ps = int'((k + 4 - (c + 1)) % 4);
        for (int p = 0; p < 2; p++) begin
          ex_v[c][p] = hv[c][p][ps];
          if (ex_v[c][p]) ex_rd[c][p] = hd[c][p][ps];
        end
      end
      ex_id = (k >= DEPTH + 1);
    end
    #1;
    for (int c = 0; c < 2; c++) begin
      string pf;
      pf = (c == 0) ? "u0" : "u1";
      chk({pf, ".init_done"}, 32'(id[c]), 32'(ex_id));
      chk({pf, ".a_rvalid"},  32'(av[c]), 32'(ex_v[c][0]));
      chk({pf, ".b_rvalid"},  32'(bv[c]), 32'(ex_v[c][1]));
      chk({pf, ".a_rdata"},   32'(ar[c]), 32'(ex_rd[c][0]));
      chk({pf, ".b_rdata"},   32'(br[c]), 32'(ex_rd[c][1]));
      chk({pf, ".coll_err"},  32'(ce[c]), 32'(ex_ce[c]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    a_cs = 0; a_we = 0; a_be = '0; a_addr = '0; a_wdata = '0;
    b_cs = 0; b_we = 0; b_be = '0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic set_a(input logic cs, input logic we, input logic [BW-1:0] be,
                       input logic [AW-1:0] ad, input logic [DW-1:0] d);
    a_cs = cs; a_we = we; a_be = be; a_addr = ad; a_wdata = d;
  endtask

  task automatic set_b(input logic cs, input logic we, input logic [BW-1:0] be,
                       input logic [AW-1:0] ad, input logic [DW-1:0] d);
    b_cs = cs; b_we = we; b_be = be; b_addr = ad; b_wdata = d;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic rand_inputs(input logic allow_read);
    logic [31:0] r;
    r = $urandom;
    a_cs = r[0]; a_we = allow_read ? r[1] : 1'b1; a_be = r[3:2];
    b_cs = r[4]; b_we = allow_read ? r[5] : 1'b1; b_be = r[7:6];
    a_addr = (r[9:8] != 0) ? {2'b00, r[11:10]} : r[15:12];
    b_addr = (r[17:16] != 0) ? {2'b00, r[19:18]} : r[23:20];
    r = $urandom;
    a_wdata = r[15:0];
    b_wdata = r[31:16];
  endtask

  // Reset, release, and count edges to init_done while writes hammer both
  // ports; optionally re-assert reset after 'mid' edges of the sweep.
  task automatic run_clear(input int mid, output int edges);
    int m;
    m = mid;
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    edges = 0;
    while (edges < 100) begin
      rand_inputs(1'b0);
      @(posedge clk); #2;
      edges++;
      if (m > 0 && edges == m) begin
        @(negedge clk); rst_n = 0; idle();
        @(negedge clk); rst_n = 1;
        edges = 0;
        m = 0;
        continue;
      end
      if (id[0]) break;
      @(negedge clk);
    end
    idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int edges;
    logic [5:0] pat0, pat1;
    int n0, n1;
    logic [DW-1:0] lat_exp [3];
    idle();
    rst_n = 0;
    repeat (3) step();

    run_clear(0, edges);
    chk("init_edges_first", 32'(edges), 32'd17);
    step();

    // Preload every word with all ones.
    for (int i = 0; i < DEPTH; i++) begin
      set_a(1, 1, 2'b11, AW'(i), 16'hFFFF);
      step();
    end
    idle();
    // Reads in flight when reset hits, then a sweep reset halfway through.
    set_a(1, 0, 2'b00, 4'd3, '0);
    set_b(1, 0, 2'b00, 4'd4, '0);
    run_clear(8, edges);
    chk("init_edges_midreset", 32'(edges), 32'd17);
    step();

    // Whole array reads back zero.
    for (int i = 0; i < DEPTH; i++) begin
      set_a(1, 0, 2'b00, AW'(i), '0);
      set_b(1, 0, 2'b00, AW'(DEPTH - 1 - i), '0);
      step();
    end
    idle(); step(); step();
    chk("clear_u0_a", 32'(ar[0]), 32'h0000);
    chk("clear_u1_b", 32'(br[1]), 32'h0000);

    // Byte enables.
    set_a(1, 1, 2'b11, 4'd2, 16'hAAAA); step();
    set_a(1, 1, 2'b01, 4'd2, 16'h1234); step();
    set_a(1, 1, 2'b00, 4'd2, 16'hFFFF); step();
    set_a(1, 0, 2'b00, 4'd2, '0); step();
    idle(); step(); step();
    chk("be_u0", 32'(ar[0]), 32'hAA34);
    chk("be_u1", 32'(ar[1]), 32'hAA34);

    // Full-overlap collision at address 5.
    set_a(1, 1, 2'b11, 4'd5, 16'h1111);
    set_b(1, 1, 2'b11, 4'd5, 16'h2222);
    step(); idle();
    chk("coll_full_u0", 32'(ce[0]), 32'd1);
    chk("coll_full_u1", 32'(ce[1]), 32'd1);
    set_a(1, 0, 2'b00, 4'd5, '0); step(); idle();
    chk("coll_pulse_end_u0", 32'(ce[0]), 32'd0);
    step(); step();
    chk("coll_win_u0", 32'(ar[0]), 32'h1111);
    chk("coll_win_u1", 32'(ar[1]), 32'h2222);

    // Disjoint lanes at the same address.
    set_a(1, 1, 2'b01, 4'd5, 16'h1111);
    set_b(1, 1, 2'b10, 4'd5, 16'h2222);
    step(); idle();
    chk("coll_none_u0", 32'(ce[0]), 32'd0);
    chk("coll_none_u1", 32'(ce[1]), 32'd0);
    set_b(1, 0, 2'b00, 4'd5, '0); step(); idle(); step(); step();
    chk("merge_u0", 32'(br[0]), 32'h2211);
    chk("merge_u1", 32'(br[1]), 32'h2211);

    // Cross-port read during write at address 7.
    set_a(1, 1, 2'b11, 4'd7, 16'h0F0F); step();
    set_a(1, 1, 2'b11, 4'd7, 16'hBEEF);
    set_b(1, 0, 2'b00, 4'd7, '0);
    step(); idle(); step(); step();
    chk("rdw_write_first", 32'(br[0]), 32'hBEEF);
    chk("rdw_read_first",  32'(br[1]), 32'h0F0F);

    // Latency: three back-to-back reads of addresses 0,1,2.
    for (int i = 0; i < 3; i++) begin
      lat_exp[i] = 16'h0A00 + 16'(i);
      set_a(1, 1, 2'b11, AW'(i), lat_exp[i]); step();
    end
    pat0 = '0; pat1 = '0; n0 = 0; n1 = 0;
    for (int j = 0; j < 6; j++) begin
      if (j < 3) set_a(1, 0, 2'b00, AW'(j), '0);
      else       idle();
      step();
      pat0[j] = av[0];
      pat1[j] = av[1];
      if (av[0] && n0 < 3) begin chk("lat_data_u0", 32'(ar[0]), 32'(lat_exp[n0])); n0++; end
      if (av[1] && n1 < 3) begin chk("lat_data_u1", 32'(ar[1]), 32'(lat_exp[n1])); n1++; end
    end
    chk("lat_pattern_u0", 32'(pat0), 32'b001110);
    chk("lat_pattern_u1", 32'(pat1), 32'b011100);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs(1'b1);
      rst_n = ($urandom_range(0, 799) != 0);
      step();
    end
    rst_n = 1;
    idle();
    repeat (25) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
